// File: rtl/cuenta_regresiva.sv
// cuenta_regresiva: MM:SS countdown timer with BCD digit outputs.
// A BCD start value is loaded, then decremented once per one-second tick
// (TICK_DIV clock cycles). Reaching 00:00 raises alarm until ack or load.
module cuenta_regresiva #(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] ld_md,
    input  logic [3:0] ld_mu,
    input  logic [3:0] ld_sd,
    input  logic [3:0] ld_su,
    input  logic       start,
    input  logic       pause,
    input  logic       ack,
    output logic [3:0] md,
    output logic [3:0] mu,
    output logic [3:0] sd,
    output logic [3:0] su,
    output logic       running,
    output logic       alarm
);

    // Prescaler is at least one bit wide so TICK_DIV=1 still elaborates;
    // in that case it stays at zero and every RUN edge is a tick.
    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    md_q, md_d;
    logic [3:0]    mu_q, mu_d;
    logic [3:0]    sd_q, sd_d;
    logic [3:0]    su_q, su_d;
    logic [PW-1:0] presc_q, presc_d;

    logic       is_zero;
    logic       is_one;
    logic       tick;
    logic       go;
    logic [3:0] md_dec, mu_dec, sd_dec, su_dec;
    logic       brw_su, brw_sd, brw_mu;

    function automatic logic [3:0] clamp_tens(input logic [3:0] v);
        return (v > 4'd5) ? 4'd5 : v;
    endfunction

    function automatic logic [3:0] clamp_units(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    assign is_zero = (md_q == 4'd0) && (mu_q == 4'd0) && (sd_q == 4'd0) && (su_q == 4'd0);
    assign is_one  = (md_q == 4'd0) && (mu_q == 4'd0) && (sd_q == 4'd0) && (su_q == 4'd1);
    assign tick    = (state_q == S_RUN) && (presc_q == PRESC_LAST);
    // A start request that actually launches the countdown (load has priority,
    // simultaneous pause cancels it, and 00:00 has nothing to count).
    assign go      = !load && start && !pause && !is_zero;

    // BCD borrow chain for the one-second decrement; md never underflows
    // because 00:00 is never decremented.
    always_comb begin
        brw_su = (su_q == 4'd0);
        su_dec = brw_su ? 4'd9 : su_q - 4'd1;
        brw_sd = brw_su && (sd_q == 4'd0);
        sd_dec = brw_su ? ((sd_q == 4'd0) ? 4'd5 : sd_q - 4'd1) : sd_q;
        brw_mu = brw_sd && (mu_q == 4'd0);
        mu_dec = brw_sd ? ((mu_q == 4'd0) ? 4'd9 : mu_q - 4'd1) : mu_q;
        md_dec = brw_mu ? md_q - 4'd1 : md_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_PAUSED: begin
                if (go) state_d = S_RUN;
            end
            S_RUN: begin
                // Reaching 00:00 takes precedence over a same-edge pause.
                if (tick && is_one) state_d = S_DONE;
                else if (pause)     state_d = S_PAUSED;
            end
            S_DONE: begin
                if (load || ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Digit and prescaler next values
    always_comb begin
        md_d    = md_q;
        mu_d    = mu_q;
        sd_d    = sd_q;
        su_d    = su_q;
        presc_d = presc_q;
        case (state_q)
            S_IDLE, S_PAUSED, S_DONE: begin
                if (load) begin
                    md_d = clamp_tens(ld_md);
                    mu_d = clamp_units(ld_mu);
                    sd_d = clamp_tens(ld_sd);
                    su_d = clamp_units(ld_su);
                end else if (go && state_q == S_IDLE) begin
                    // A fresh run starts a full second; a resumed one keeps its phase.
                    presc_d = '0;
                end
            end
            S_RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    md_d = md_dec;
                    mu_d = mu_dec;
                    sd_d = sd_dec;
                    su_d = su_dec;
                end
            end
            default: ;
        endcase
    end

    // Digit and prescaler registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_q    <= 4'd0;
            mu_q    <= 4'd0;
            sd_q    <= 4'd0;
            su_q    <= 4'd0;
            presc_q <= '0;
        end else begin
            md_q    <= md_d;
            mu_q    <= mu_d;
            sd_q    <= sd_d;
            su_q    <= su_d;
            presc_q <= presc_d;
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        running = (state_q == S_RUN);
        alarm   = (state_q == S_DONE);
    end

    assign md = md_q;
    assign mu = mu_q;
    assign sd = sd_q;
    assign su = su_q;

endmodule

// File: tb/tb_cuenta_regresiva.sv
// Testbench for cuenta_regresiva: directed scenarios plus randomized traffic
// checked against a seconds-based reference model.
`timescale 1ns/1ps
module tb_cuenta_regresiva;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       load, start, pause, ack;
    logic [3:0] ld_md, ld_mu, ld_sd, ld_su;
    logic [3:0] md, mu, sd, su;
    logic       running, alarm;

    logic       load4, start4, pause4, ack4;
    logic [3:0] ld4_md, ld4_mu, ld4_sd, ld4_su;
    logic [3:0] md4, mu4, sd4, su4;
    logic       running4, alarm4;

    logic [17:0] obs, obs4;
    assign obs  = {md, mu, sd, su, running, alarm};
    assign obs4 = {md4, mu4, sd4, su4, running4, alarm4};

    int n_checks = 0;
    int n_fail   = 0;

    cuenta_regresiva #(.TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .load(load),
        .ld_md(ld_md), .ld_mu(ld_mu), .ld_sd(ld_sd), .ld_su(ld_su),
        .start(start), .pause(pause), .ack(ack),
        .md(md), .mu(mu), .sd(sd), .su(su),
        .running(running), .alarm(alarm)
    );

    cuenta_regresiva #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .load(load4),
        .ld_md(ld4_md), .ld_mu(ld4_mu), .ld_sd(ld4_sd), .ld_su(ld4_su),
        .start(start4), .pause(pause4), .ack(ack4),
        .md(md4), .mu(mu4), .sd(sd4), .su(su4),
        .running(running4), .alarm(alarm4)
    );

    // Reference model: remaining time as a plain count of seconds.
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSED = 2, ST_DONE = 3;
    localparam int MODEL_TD = 1;
    int m_st    = ST_IDLE;
    int m_secs  = 0;
    int m_presc = 0;

    function automatic logic [17:0] vec(input int mm, input int ss, input logic r, input logic a);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), r, a};
    endfunction

    function automatic logic [17:0] exp_vec();
        return vec(m_secs / 60, m_secs % 60, m_st == ST_RUN, m_st == ST_DONE);
    endfunction

    function automatic int load_secs(input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] c, input logic [3:0] d);
        int t, u, s10, s1;
        t   = (a > 5) ? 5 : int'(a);
        u   = (b > 9) ? 9 : int'(b);
        s10 = (c > 5) ? 5 : int'(c);
        s1  = (d > 9) ? 9 : int'(d);
        return (t * 10 + u) * 60 + s10 * 10 + s1;
    endfunction

    task automatic model_step(input logic l, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d,
                              input logic s, input logic p, input logic k);
        case (m_st)
            ST_IDLE, ST_PAUSED: begin
                if (l) m_secs = load_secs(a, b, c, d);
                else if (s && !p && m_secs != 0) begin
                    if (m_st == ST_IDLE) m_presc = 0;
                    m_st = ST_RUN;
                end
            end
            ST_RUN: begin
                if (m_presc == MODEL_TD - 1) begin
                    m_presc = 0;
                    m_secs  = m_secs - 1;
                    if (m_secs == 0) m_st = ST_DONE;
                    else if (p)      m_st = ST_PAUSED;
                end else begin
                    m_presc = m_presc + 1;
                    if (p) m_st = ST_PAUSED;
                end
            end
            default: begin
                if (l) begin
                    m_secs = load_secs(a, b, c, d);
                    m_st   = ST_IDLE;
                end else if (k) m_st = ST_IDLE;
            end
        endcase
    endtask

    task automatic model_reset();
        m_st = ST_IDLE; m_secs = 0; m_presc = 0;
    endtask

    // Drive one clock edge on the TICK_DIV=1 instance and advance the model.
    task automatic cycle(input logic l, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d,
                         input logic s, input logic p, input logic k);
        load = l; ld_md = a; ld_mu = b; ld_sd = c; ld_su = d;
        start = s; pause = p; ack = k;
        @(posedge clk);
        model_step(l, a, b, c, d, s, p, k);
        #1;
        load = 0; start = 0; pause = 0; ack = 0;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== 18'd0) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs, 18'd0);
        end
        n_checks++;
        if (obs4 !== 18'd0) begin
            n_fail++; $display("FAIL reset_state_div4: got %h expected %h", obs4, 18'd0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_countdown();
        do_reset();
        cycle(1, 0, 0, 0, 3, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (obs !== vec(0, 3, 1, 0)) begin
            n_fail++; $display("FAIL cd_start: got %h expected %h", obs, vec(0, 3, 1, 0));
        end
        for (int i = 2; i >= 0; i--) begin
            idle();
            n_checks++;
            if (obs !== vec(0, i, i != 0, i == 0)) begin
                n_fail++; $display("FAIL cd_edge_%0d: got %h expected %h", 3 - i, obs, vec(0, i, i != 0, i == 0));
            end
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (obs !== vec(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL cd_ack: got %h expected %h", obs, vec(0, 0, 0, 0));
        end
    endtask

    task automatic test_borrow();
        do_reset();
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        n_checks++;
        if (obs !== vec(9, 59, 1, 0)) begin
            n_fail++; $display("FAIL borrow_10_00: got %h expected %h", obs, vec(9, 59, 1, 0));
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 5, 9, 5, 9, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3599; i++) begin
            idle();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL borrow_tick_%0d: got %h expected %h", i + 1, obs, exp_vec());
            end
        end
        n_checks++;
        if (obs !== vec(0, 0, 0, 1)) begin
            n_fail++; $display("FAIL borrow_59_59_alarm: got %h expected %h", obs, vec(0, 0, 0, 1));
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_tickdiv4();
        logic [17:0] want;
        int secs;
        do_reset();
        load4 = 1; ld4_md = 0; ld4_mu = 0; ld4_sd = 1; ld4_su = 0;
        @(posedge clk); #1;
        load4 = 0;
        for (int e = 0; e <= 16; e++) begin
            start4 = (e == 0 || e == 10);
            pause4 = (e == 6);
            @(posedge clk); #1;
            start4 = 0; pause4 = 0;
            secs = (e < 4) ? 10 : (e < 12) ? 9 : (e < 16) ? 8 : 7;
            want = vec(0, secs, !(e >= 6 && e < 10), 1'b0);
            n_checks++;
            if (obs4 !== want) begin
                n_fail++; $display("FAIL div4_edge_%0d: got %h expected %h", e, obs4, want);
            end
        end
    endtask

    task automatic test_clamp_ignore();
        do_reset();
        cycle(1, 7, 12, 6, 15, 0, 0, 0);
        n_checks++;
        if (obs !== vec(59, 59, 0, 0)) begin
            n_fail++; $display("FAIL clamp: got %h expected %h", obs, vec(59, 59, 0, 0));
        end
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 5, 0, 0, 0);
        n_checks++;
        if (obs !== vec(59, 58, 1, 0)) begin
            n_fail++; $display("FAIL load_in_run: got %h expected %h", obs, vec(59, 58, 1, 0));
        end
        do_reset();
        cycle(1, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (obs !== vec(0, 0, 0, 0)) begin
            n_fail++; $display("FAIL start_at_zero: got %h expected %h", obs, vec(0, 0, 0, 0));
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        cycle(1, 0, 1, 3, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        repeat (5) idle();
        n_checks++;
        if (obs !== vec(1, 25, 1, 0)) begin
            n_fail++; $display("FAIL run_5_ticks: got %h expected %h", obs, vec(1, 25, 1, 0));
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 18'd0) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", obs, 18'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_edge_cases();
        do_reset();
        cycle(1, 0, 0, 0, 2, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (obs !== vec(0, 0, 0, 1)) begin
            n_fail++; $display("FAIL pause_on_last_tick: got %h expected %h", obs, vec(0, 0, 0, 1));
        end
        cycle(0, 0, 0, 0, 0, 1, 1, 0);
        n_checks++;
        if (obs !== vec(0, 0, 0, 1)) begin
            n_fail++; $display("FAIL done_ignores_start: got %h expected %h", obs, vec(0, 0, 0, 1));
        end
        cycle(1, 0, 0, 0, 5, 0, 0, 1);
        n_checks++;
        if (obs !== vec(0, 5, 0, 0)) begin
            n_fail++; $display("FAIL done_load_ack: got %h expected %h", obs, vec(0, 5, 0, 0));
        end
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (obs !== vec(0, 4, 0, 0)) begin
            n_fail++; $display("FAIL pause_tick: got %h expected %h", obs, vec(0, 4, 0, 0));
        end
        cycle(0, 0, 0, 0, 0, 1, 1, 0);
        n_checks++;
        if (obs !== vec(0, 4, 0, 0)) begin
            n_fail++; $display("FAIL start_pause_paused: got %h expected %h", obs, vec(0, 4, 0, 0));
        end
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (obs !== vec(0, 3, 1, 0)) begin
            n_fail++; $display("FAIL ack_in_run: got %h expected %h", obs, vec(0, 3, 1, 0));
        end
    endtask

    task automatic test_random();
        logic       l, s, p, k;
        logic [3:0] a, b, c, d;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            l = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
                c = 4'($urandom_range(0, 15)); d = 4'($urandom_range(0, 15));
            end else begin
                a = 0; b = 0;
                c = 4'($urandom_range(0, 1)); d = 4'($urandom_range(0, 15));
            end
            s = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 9) == 0);
            k = ($urandom_range(0, 5) == 0);
            cycle(l, a, b, c, d, s, p, k);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        load = 0; start = 0; pause = 0; ack = 0;
        ld_md = 0; ld_mu = 0; ld_sd = 0; ld_su = 0;
        load4 = 0; start4 = 0; pause4 = 0; ack4 = 0;
        ld4_md = 0; ld4_mu = 0; ld4_sd = 0; ld4_su = 0;
        rst = 1'b1;
        test_reset();
        test_countdown();
        test_borrow();
        test_tickdiv4();
        test_clamp_ignore();
        test_reset_mid_run();
        test_edge_cases();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
